wave_capture_scheduler: RTL and testbench

- Shares one waveform-RAM write port among four sample streams: mixed output plus voices one, two and three from music_player.
- Each stream has a 1-deep holding register; pending samples are granted round-robin and written to that stream's RAM region.
- A frame-synchronous run/freeze FSM changes capture state only on frame_start, so the wave display never shows a half-updated frame.
- Sits between the flopped sample registers and the shared wave display RAM, in the clk_100 domain.

---
 rtl/wave_capture_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_wave_capture_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture_scheduler.sv
// Shares one waveform-RAM write port among four sample streams with round-robin grant
// and a frame-synchronous run/freeze FSM. Optional feature macro: WCS_ZERO_CROSS_TRIG_EN.
module wave_capture_scheduler #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned NUM_SRC  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*SAMPLE_W-1:0]   src_sample,
    input  logic                          frame_start,
    input  logic                          freeze_req,
    input  logic                          ovf_clear,
    input  logic                          wr_ready,
    output logic                          wr_en,
    output logic [1:0]                    wr_src,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [SAMPLE_W-1:0]           wr_data,
    output logic                          frozen,
    output logic [NUM_SRC-1:0]            ovf_flags
);

    localparam int unsigned SRC_W = 2;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        RUN         = 2'd1,
        FREEZE_PEND = 2'd2,
        FROZEN      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  frozen_q, frozen_d;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [SAMPLE_W-1:0]   hold_q [NUM_SRC];
    logic [SAMPLE_W-1:0]   hold_d [NUM_SRC];
    logic [ADDR_W-1:0]     addr_q [NUM_SRC];
    logic [ADDR_W-1:0]     addr_d [NUM_SRC];
    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [NUM_SRC-1:0]    ovf_q, ovf_d;
    logic                  wr_en_q, wr_en_d;
    logic [SRC_W-1:0]      wr_src_q, wr_src_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [SAMPLE_W-1:0]   wr_data_q, wr_data_d;

`ifdef WCS_ZERO_CROSS_TRIG_EN
    logic [NUM_SRC-1:0]    trig_q, trig_d;
    logic [NUM_SRC-1:0]    prev_msb_q, prev_msb_d;
    logic [NUM_SRC-1:0]    zero_q, zero_d;
`endif

    logic                  capture_en;
    logic                  gnt_vld;
    logic [SRC_W-1:0]      gnt_idx;
    logic [SRC_W-1:0]      cand;
    logic                  take;
    logic [SAMPLE_W-1:0]   sample;
    logic [ADDR_W-1:0]     gnt_addr;

    // Run/freeze FSM: capture state only moves on frame boundaries
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (frame_start) state_d = RUN;
            RUN:         if (freeze_req) state_d = FREEZE_PEND;
            FREEZE_PEND: begin
                if (!freeze_req)      state_d = RUN;
                else if (frame_start) state_d = FROZEN;
            end
            FROZEN:      if (!freeze_req && frame_start) state_d = RUN;
            default:     state_d = IDLE;
        endcase
        frozen_d = (state_d == FROZEN);
    end

    assign capture_en = (state_q == RUN) || (state_q == FREEZE_PEND);

    // Round-robin search starting at the pointer
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = ptr_q + SRC_W'(k);
            if (wr_ready && !gnt_vld && pending_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

`ifdef WCS_ZERO_CROSS_TRIG_EN
    assign gnt_addr = zero_q[gnt_idx] ? '0 : addr_q[gnt_idx];
`else
    assign gnt_addr = addr_q[gnt_idx];
`endif

    // Grant, write-output and capture next-state logic
    always_comb begin
        pending_d = pending_q;
        hold_d    = hold_q;
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        ovf_d     = ovf_clear ? '0 : ovf_q;
        wr_en_d   = 1'b0;
        wr_src_d  = wr_src_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        take      = 1'b0;
        sample    = '0;
`ifdef WCS_ZERO_CROSS_TRIG_EN
        trig_d     = trig_q;
        prev_msb_d = prev_msb_q;
        zero_d     = zero_q;
        if (state_d == RUN && state_q != RUN) trig_d = '1;
`endif

        if (gnt_vld) begin
            pending_d[gnt_idx] = 1'b0;
            ptr_d              = gnt_idx + SRC_W'(1);
            wr_en_d            = 1'b1;
            wr_src_d           = gnt_idx;
            wr_data_d          = hold_q[gnt_idx];
            wr_addr_d          = gnt_addr;
            addr_d[gnt_idx]    = gnt_addr + ADDR_W'(1);
`ifdef WCS_ZERO_CROSS_TRIG_EN
            zero_d[gnt_idx]    = 1'b0;
`endif
        end

        // Capture happens after the grant so a same-cycle reload wins over the clear
        for (int i = 0; i < NUM_SRC; i++) begin
            if (capture_en && src_valid[i]) begin
                sample = src_sample[i*SAMPLE_W +: SAMPLE_W];
                take   = 1'b1;
`ifdef WCS_ZERO_CROSS_TRIG_EN
                if (trig_q[i]) take = prev_msb_q[i] && !sample[SAMPLE_W-1];
                prev_msb_d[i] = sample[SAMPLE_W-1];
`endif
                if (take) begin
                    if (!pending_q[i] || (gnt_vld && gnt_idx == SRC_W'(i))) begin
                        hold_d[i]    = sample;
                        pending_d[i] = 1'b1;
`ifdef WCS_ZERO_CROSS_TRIG_EN
                        if (trig_q[i]) begin
                            trig_d[i] = 1'b0;
                            zero_d[i] = 1'b1;
                        end
`endif
                    end else begin
                        ovf_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            frozen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            frozen_q <= frozen_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            ptr_q     <= '0;
            ovf_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_src_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_src_q  <= wr_src_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_q[i] <= hold_d[i];
                addr_q[i] <= addr_d[i];
            end
        end
    end

`ifdef WCS_ZERO_CROSS_TRIG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q     <= '0;
            prev_msb_q <= '0;
            zero_q     <= '0;
        end else begin
            trig_q     <= trig_d;
            prev_msb_q <= prev_msb_d;
            zero_q     <= zero_d;
        end
    end
`endif

    assign wr_en     = wr_en_q;
    assign wr_src    = wr_src_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frozen    = frozen_q;
    assign ovf_flags = ovf_q;

endmodule

// File: tb/tb_wave_capture_scheduler.sv
// Directed bench for wave_capture_scheduler: expected writes are queued as stimulus
// is driven and checked in order when the DUT strobes wr_en.
module tb_wave_capture_scheduler;

    localparam int unsigned SW = 16;
    localparam int unsigned AW = 9;

    typedef struct packed {
        logic [1:0]    src;
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      src_valid;
    logic [4*SW-1:0] src_sample;
    logic            frame_start, freeze_req, ovf_clear, wr_ready;
    logic            wr_en;
    logic [1:0]      wr_src;
    logic [AW-1:0]   wr_addr;
    logic [SW-1:0]   wr_data;
    logic            frozen;
    logic [3:0]      ovf_flags;

    int            total = 0;
    int            bad   = 0;
    int            wr_cnt = 0;
    int            wc;
    int            n0;
    bit            wrap_seen = 1'b0;
    logic [AW-1:0] last_a3 = '0;
    wr_t           exp_q[$];
    logic [AW-1:0] exp_addr [4];

    wave_capture_scheduler #(.SAMPLE_W(SW), .ADDR_W(AW), .NUM_SRC(4)) dut (
        .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_sample(src_sample),
        .frame_start(frame_start), .freeze_req(freeze_req), .ovf_clear(ovf_clear),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_src(wr_src), .wr_addr(wr_addr),
        .wr_data(wr_data), .frozen(frozen), .ovf_flags(ovf_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [SW-1:0] sdata(input int i, input logic [SW-1:0] base);
        return base + SW'(i) * 16'h1111;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s, input logic [SW-1:0] d);
        exp_q.push_back({s, exp_addr[s], d});
        exp_addr[s] = exp_addr[s] + AW'(1);
    endtask

    task automatic strobe(input logic [3:0] m, input logic [SW-1:0] base);
        src_valid = m;
        for (int i = 0; i < 4; i++) src_sample[i*SW +: SW] = sdata(i, base);
        cycle();
        src_valid = '0;
    endtask

    task automatic strobe_one(input logic [1:0] s, input logic [SW-1:0] d);
        src_valid = 4'b0001 << s;
        src_sample[int'(s)*SW +: SW] = d;
        cycle();
        src_valid = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        cycle();
    endtask

    // Scoreboard: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (reset_n === 1'b1 && wr_en === 1'b1) begin
            wr_t e;
            wr_cnt++;
            if (wr_src == 2'd3) begin
                if (wr_addr == '0 && last_a3 == AW'(511)) wrap_seen = 1'b1;
                last_a3 = wr_addr;
            end
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write observed src=%0d addr=%0d data=%0h expected=none",
                       wr_src, wr_addr, wr_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write", {5'b0, wr_src, wr_addr, wr_data}, {5'b0, e});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        src_valid = '0; src_sample = '0;
        frame_start = 1'b0; freeze_req = 1'b0; ovf_clear = 1'b0; wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_addr[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frozen", 32'(frozen), 32'd0);
        chk("rst_ovf", 32'(ovf_flags), 32'd0);
        reset_n = 1'b1;
        cycle();
        frame_start = 1'b1; cycle(); frame_start = 1'b0;

        // single write latency and one-cycle pulse
        push(2'd0, 16'h1234);
        src_valid = 4'b0001; src_sample[SW-1:0] = 16'h1234;
        cycle(); src_valid = '0;
        chk("lat_e1_wr_en", 32'(wr_en), 32'd0);
        cycle();
        chk("lat_e2_wr_en", 32'(wr_en), 32'd1);
        chk("lat_wr_src", 32'(wr_src), 32'd0);
        chk("lat_wr_addr", 32'(wr_addr), 32'd0);
        chk("lat_wr_data", 32'(wr_data), 32'h1234);
        cycle();
        chk("pulse_wr_en", 32'(wr_en), 32'd0);
        chk("hold_wr_data", 32'(wr_data), 32'h1234);
        push(2'd0, 16'h5678); strobe_one(2'd0, 16'h5678); drain(20);

        // pointer back to 0, then two full bursts
        push(2'd3, 16'h0333); strobe_one(2'd3, 16'h0333); drain(20);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) push(2'(i), sdata(i, 16'h2000 + 16'(r)));
            strobe(4'b1111, 16'h2000 + 16'(r));
            drain(20);
        end

        // overflow with stalled port; set wins over a coincident clear
        wr_ready = 1'b0;
        strobe(4'b0100, 16'hA000);
        strobe(4'b0100, 16'hB000);
        chk("ovf_set", 32'(ovf_flags), 32'h4);
        strobe(4'b0010, 16'hC000);
        ovf_clear = 1'b1;
        strobe(4'b0010, 16'hD000);
        ovf_clear = 1'b0;
        chk("ovf_set_wins", 32'(ovf_flags), 32'h2);
        ovf_clear = 1'b1; cycle(); ovf_clear = 1'b0;
        chk("ovf_clear", 32'(ovf_flags), 32'h0);
        push(2'd1, sdata(1, 16'hC000));
        push(2'd2, sdata(2, 16'hA000));
        wr_ready = 1'b1;
        drain(20);

        // freeze only takes effect at a frame boundary
        freeze_req = 1'b1;
        repeat (3) cycle();
        chk("freeze_wait", 32'(frozen), 32'd0);
        push(2'd0, 16'hE000); strobe_one(2'd0, 16'hE000); drain(20);
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        chk("frozen_set", 32'(frozen), 32'd1);
        wc = wr_cnt;
        strobe(4'b1111, 16'hF000);
        repeat (6) cycle();
        chk("frozen_no_write", 32'(wr_cnt), 32'(wc));
        chk("frozen_no_ovf", 32'(ovf_flags), 32'h0);
        freeze_req = 1'b0; cycle();
        chk("frozen_hold", 32'(frozen), 32'd1);
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        chk("unfrozen", 32'(frozen), 32'd0);
        push(2'd0, 16'h1357); strobe_one(2'd0, 16'h1357); drain(20);

        // address wrap on source 3: bring counter to 0, then 513 writes
        n0 = 512 - int'(exp_addr[3]);
        for (int k = 0; k < n0 + 513; k++) begin
            push(2'd3, 16'(k));
            strobe_one(2'd3, 16'(k));
        end
        drain(20);
        chk("addr_wrap", 32'(wrap_seen), 32'd1);
        chk("addr_after_wrap", 32'(last_a3), 32'd0);

        // asynchronous reset with samples pending
        src_valid = 4'b1111;
        for (int i = 0; i < 4; i++) src_sample[i*SW +: SW] = sdata(i, 16'h4444);
        cycle(); src_valid = '0;
        cycle();
        chk("pre_reset_wr_en", 32'(wr_en), 32'd1);
        #1 reset_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_addr[i] = '0;
        #1;
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        chk("async_rst_wr_data", 32'(wr_data), 32'd0);
        chk("async_rst_wr_addr", 32'(wr_addr), 32'd0);
        repeat (2) cycle();
        reset_n = 1'b1;
        wc = wr_cnt;
        repeat (8) cycle();
        strobe_one(2'd0, 16'h1111);
        repeat (4) cycle();
        chk("no_wr_after_reset", 32'(wr_cnt), 32'(wc));
        frame_start = 1'b1; cycle(); frame_start = 1'b0;
        push(2'd2, 16'hBEEF); strobe_one(2'd2, 16'hBEEF); drain(20);
        chk("final_ovf", 32'(ovf_flags), 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
